// File: rtl/ay_bus_master.sv
// rtl/ay_bus_master.sv - TurboSound AY write replayer acting as a second I/O bus master
// Queues (chip, reg, value) writes and replays them as #FFFD/#BFFD I/O write cycles.
module ay_bus_master #(
  parameter int DEPTH      = 4,
  parameter int STROBE_LEN = 4,
  parameter int GAP_LEN    = 4
) (
  input  logic        clk28,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic        wr_chip,
  input  logic [3:0]  wr_reg,
  input  logic [7:0]  wr_data,
  input  logic        bus_grant,
  output logic        busy,
  output logic        m_ioreq,
  output logic        m_wr,
  output logic [15:0] m_a,
  output logic [7:0]  m_d,
  input  logic        sel_flush
);

  localparam int AW     = $clog2(DEPTH);
  localparam int MAXLEN = (STROBE_LEN > GAP_LEN) ? STROBE_LEN : GAP_LEN;
  localparam int CW     = $clog2(MAXLEN);
  localparam logic [CW-1:0] STB_LOAD = CW'(STROBE_LEN - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_LEN - 1);
  localparam logic [15:0] PORT_SEL = 16'hFFFD;
  localparam logic [15:0] PORT_DAT = 16'hBFFD;

  typedef enum logic [2:0] {
    IDLE, SEL_STB, SEL_GAP, ADR_STB, ADR_GAP, DAT_STB, DAT_GAP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          sel_valid;
  logic          sel_chip;
  logic [3:0]    h_reg;
  logic [7:0]    h_data;

  // Write queue: pointers carry an extra wrap bit to tell full from empty.
  logic [12:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic        full, empty, push, pop;
  logic [12:0] head;

  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty    = (wptr == rptr);
  assign wr_ready = !full;
  assign push     = wr_valid && !full;
  assign pop      = (state == IDLE) && !empty && bus_grant;
  assign head     = mem[rptr[AW-1:0]];
  assign m_wr     = m_ioreq;

  always_ff @(posedge clk28) begin
    if (push) mem[wptr[AW-1:0]] <= {wr_chip, wr_reg, wr_data};
  end

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      m_ioreq   <= 1'b0;
      m_a       <= 16'h0000;
      m_d       <= 8'h00;
      sel_valid <= 1'b0;
      sel_chip  <= 1'b0;
      h_reg     <= 4'h0;
      h_data    <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            h_reg   <= head[11:8];
            h_data  <= head[7:0];
            busy    <= 1'b1;
            cnt     <= STB_LOAD;
            m_ioreq <= 1'b1;
            m_a     <= PORT_SEL;
            if (!sel_valid || head[12] != sel_chip) begin
              state     <= SEL_STB;
              m_d       <= {7'h7F, head[12]};
              sel_valid <= 1'b1;
              sel_chip  <= head[12];
            end else begin
              state <= ADR_STB;
              m_d   <= {4'h0, head[11:8]};
            end
          end
        end
        SEL_STB, ADR_STB, DAT_STB: begin
          if (cnt == '0) begin
            state   <= (state == SEL_STB) ? SEL_GAP :
                       (state == ADR_STB) ? ADR_GAP : DAT_GAP;
            cnt     <= GAP_LOAD;
            m_ioreq <= 1'b0;
            m_a     <= 16'h0000;
            m_d     <= 8'h00;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SEL_GAP: begin
          if (cnt == '0) begin
            state   <= ADR_STB;
            cnt     <= STB_LOAD;
            m_ioreq <= 1'b1;
            m_a     <= PORT_SEL;
            m_d     <= {4'h0, h_reg};
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ADR_GAP: begin
          if (cnt == '0) begin
            state   <= DAT_STB;
            cnt     <= STB_LOAD;
            m_ioreq <= 1'b1;
            m_a     <= PORT_DAT;
            m_d     <= h_data;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DAT_GAP: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          m_ioreq <= 1'b0;
        end
      endcase
      // Flush wins over a select recorded on this same edge.
      if (sel_flush) sel_valid <= 1'b0;
    end
  end

endmodule
